// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU datapath memory interface. A request
//   (word address, write data, write enable) is accepted in IDLE, held for a
//   programmable number of wait states, then serviced against an internal
//   word RAM in a single ACCESS cycle. Completion is signalled by a one-cycle
//   ack pulse with registered read data and an out-of-range error flag.
//
// Ports
//   clk    in   1       rising-edge clock
//   rst    in   1       asynchronous, active-low reset
//   req    in   1       request, sampled only in IDLE
//   we     in   1       1 = write, 0 = read; captured with req
//   addr   in   ADDR_W  word address; captured with req
//   wdata  in   DATA_W  write data; captured with req
//   rdata  out  DATA_W  registered read data, valid with ack
//   ack    out  1       one-cycle completion pulse per request
//   err    out  1       out-of-range address flag, qualified by ack
//   busy   out  1       high while a transaction is in progress
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              in_range_p0;
  logic [IDX_W-1:0]  idx_p0;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Range check on the full word address: upper bits are never dropped, so
  // an address at or beyond DEPTH cannot alias onto a low location.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (64'(a) < 64'(DEPTH));
  endfunction

  assign in_range_p0 = addr_in_range(addr_p0);
  assign idx_p0      = addr_p0[IDX_W-1:0];
  assign busy        = (state != S_IDLE);

  // ---- request capture stage (p0): held stable through WAIT and ACCESS ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // Next-state logic. cnt is loaded with the wait-state count on acceptance
  // and the last wait cycle is the one where cnt reads 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- access stage: state, response flags and read data ----
  // ack is a pure function of "previous cycle was ACCESS", which makes it a
  // one-cycle pulse landing in the IDLE cycle that follows. err and rdata
  // only move in ACCESS, so they hold between transactions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= (state == S_ACCESS);
      if (state == S_ACCESS) begin
        err <= !in_range_p0;
        if (!in_range_p0) begin
          rdata <= '0;
        end else if (!we_p0) begin
          rdata <= mem[idx_p0];
        end
      end
    end
  end

  // RAM write port. No reset: contents survive rst. A reset during WAIT
  // forces state to IDLE, so an aborted write never reaches this port.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && we_p0 && in_range_p0) begin
      mem[idx_p0] <= wdata_p0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Directed and randomized checks of mem_responder on three instances:
//   unit 0: WAIT_CYCLES=2, DEPTH=4096
//   unit 1: WAIT_CYCLES=0, DEPTH=4096
//   unit 2: WAIT_CYCLES=2, DEPTH=2048
//   Expected results come from a word-addressed reference memory and the
//   latency rule ack = sample edge + WAIT_CYCLES + 1.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]       req = '0;
  logic [2:0]       we = '0;
  logic [2:0][11:0] addr = '0;
  logic [2:0][15:0] wdata = '0;
  logic [2:0][15:0] rdata;
  logic [2:0]       ack;
  logic [2:0]       err;
  logic [2:0]       busy;

  int tests = 0;
  int fails = 0;

  int wc  [3] = '{2, 0, 2};
  int dep [3] = '{4096, 4096, 2048};

  // Reference model: written words per unit, plus last returned read data.
  logic [15:0] mdl [int];
  logic [15:0] last_rd [3];
  bit          lk [3];

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [15:0] d;
  } txn_t;
  txn_t q[$];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2), .DEPTH(4096)) u_w2 (
    .clk(clk), .rst(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );
  mem_responder #(.WAIT_CYCLES(0), .DEPTH(4096)) u_w0 (
    .clk(clk), .rst(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );
  mem_responder #(.WAIT_CYCLES(2), .DEPTH(2048)) u_d2k (
    .clk(clk), .rst(rst_n), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 16'h0;
      lk[i]      = 1'b1;
    end
  endtask

  // Apply one transaction to the model and return what the DUT should show.
  task automatic predict(input int u, input logic w, input logic [11:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic er, output bit known);
    int key;
    key = u * 65536 + int'(a);
    if (int'(a) >= dep[u]) begin
      rd = 16'h0; er = 1'b1; known = 1'b1;
      last_rd[u] = 16'h0; lk[u] = 1'b1;
    end else if (w) begin
      rd = last_rd[u]; er = 1'b0; known = lk[u];
      mdl[key] = d;
    end else begin
      known = mdl.exists(key);
      rd = known ? mdl[key] : 16'h0;
      er = 1'b0;
      last_rd[u] = rd; lk[u] = known;
    end
  endtask

  // One isolated transaction with latency, busy-width and result checks.
  task automatic txn(input int u, input logic w, input logic [11:0] a, input logic [15:0] d);
    logic [15:0] erd;
    logic        eer;
    bit          known;
    int          n;
    int          bz;
    bit          got;
    predict(u, w, a, d, erd, eer, known);
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    @(posedge clk);
    #1;
    req[u] = 1'b0;
    we[u] = 1'($urandom); addr[u] = 12'($urandom); wdata[u] = 16'($urandom);
    n = 0; bz = 0; got = 1'b0;
    if (busy[u]) bz++;
    while (!got && n < 24) begin
      @(posedge clk);
      #1;
      n++;
      if (ack[u]) got = 1'b1;
      else if (busy[u]) bz++;
    end
    check($sformatf("u%0d ack_seen a=%0h", u, a), 32'(got), 32'd1);
    check($sformatf("u%0d latency a=%0h", u, a), 32'(n), 32'(wc[u] + 1));
    check($sformatf("u%0d busy_cycles a=%0h", u, a), 32'(bz), 32'(wc[u] + 1));
    check($sformatf("u%0d busy_at_ack", u), 32'(busy[u]), 32'd0);
    check($sformatf("u%0d err a=%0h", u, a), 32'(err[u]), 32'(eer));
    if (known) check($sformatf("u%0d rdata a=%0h we=%0b", u, a, w), 32'(rdata[u]), 32'(erd));
    @(posedge clk);
    #1;
    check($sformatf("u%0d ack_one_cycle", u), 32'(ack[u]), 32'd0);
    check($sformatf("u%0d err_hold", u), 32'(err[u]), 32'(eer));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t        t;
    logic [15:0] erd;
    logic        eer;
    bit          known;
    int          u;

    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rdata", 32'(rdata[0] | rdata[1] | rdata[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read with two wait states
    txn(0, 1'b1, 12'h010, 16'hBEEF);
    txn(0, 1'b0, 12'h010, 16'h0000);

    // Zero wait states; write leaves rdata at the previous read value
    txn(1, 1'b1, 12'h0FF, 16'h1234);
    txn(1, 1'b0, 12'h0FF, 16'h0000);
    txn(1, 1'b1, 12'h0FF, 16'h5678);
    txn(1, 1'b0, 12'h0FF, 16'h0000);

    // Out of range on the 2048-word instance, no aliasing onto 0x000
    txn(2, 1'b1, 12'h000, 16'h3C3C);
    txn(2, 1'b1, 12'h800, 16'hAAAA);
    txn(2, 1'b0, 12'h000, 16'h0000);
    txn(2, 1'b0, 12'hFFF, 16'h0000);

    // Endpoints
    txn(0, 1'b1, 12'h000, 16'hFFFF);
    txn(0, 1'b1, 12'hFFF, 16'h0000);
    txn(0, 1'b0, 12'h000, 16'h0000);
    txn(0, 1'b0, 12'hFFF, 16'h0000);
    txn(0, 1'b1, 12'h000, 16'h0000);
    txn(0, 1'b1, 12'hFFF, 16'hFFFF);
    txn(0, 1'b0, 12'hFFF, 16'h0000);
    txn(0, 1'b0, 12'h000, 16'h0000);
    txn(2, 1'b1, 12'h7FF, 16'hFFFF);
    txn(2, 1'b0, 12'h7FF, 16'h0000);

    // Randomized mix across units; unit 2 straddles its DEPTH boundary
    for (int k = 0; k < 30; k++) begin
      u = int'($urandom_range(0, 2));
      if (u == 2)
        txn(u, 1'($urandom), 12'h7F8 + 12'($urandom_range(0, 15)), 16'($urandom));
      else
        txn(u, 1'($urandom), 12'h200 + 12'($urandom_range(0, 7)), 16'($urandom));
    end

    // Back-to-back with req held high; fields change every cycle
    for (int j = 0; j < 8; j++) txn(0, 1'b1, 12'h100 + 12'(j), 16'($urandom));
    @(negedge clk);
    req[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      we[0]    = 1'($urandom);
      addr[0]  = 12'h100 + 12'($urandom_range(0, 7));
      wdata[0] = 16'($urandom);
      @(posedge clk);
      if (i % 4 == 0) q.push_back('{we[0], addr[0], wdata[0]});
      #1;
      check($sformatf("b2b ack i=%0d", i), 32'(ack[0]), 32'(i % 4 == 3));
      if (i % 4 == 3) begin
        t = q.pop_front();
        predict(0, t.w, t.a, t.d, erd, eer, known);
        check($sformatf("b2b err i=%0d", i), 32'(err[0]), 32'(eer));
        if (known) check($sformatf("b2b rdata i=%0d a=%0h", i, t.a), 32'(rdata[0]), 32'(erd));
      end
      @(negedge clk);
    end
    req[0] = 1'b0;
    check("b2b queue drained", 32'(q.size()), 32'd0);
    txn(0, 1'b0, 12'h100, 16'h0000);
    txn(0, 1'b0, 12'h107, 16'h0000);

    // Reset during WAIT of a write aborts it
    txn(0, 1'b1, 12'h020, 16'h1111);
    txn(0, 1'b0, 12'h020, 16'h0000);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h020; wdata[0] = 16'h5555;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    check("abort busy before reset", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort rdata", 32'(rdata[0]), 32'd0);
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort err", 32'(err[0]), 32'd0);
    check("abort ack", 32'(ack[0]), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort no_ack c=%0d", i), 32'(ack), 32'd0);
    end
    txn(0, 1'b0, 12'h020, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
